// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer for the accumulator processor: fetch, decode, exec, mem wait, halt.
// Optional SEQ_SINGLE_STEP_EN adds a step input that gates each FETCH.
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       opcode,
    input  logic             identifier,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             pc_clr,
    output logic             pc_en,
    output logic             pc_load,
    output logic             ir_load,
    output logic             RegWrite,
    output logic             AccWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             Lookup,
    output logic             ImmVal,
    output logic             Done,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t     cur, nxt;
    logic [3:0] op_q;
    logic       id_q;
    logic [7:0] wait_cnt;
    logic       fetch_go;
    logic       mem_last;
    logic       is_reg, is_alu, is_br;

`ifdef SEQ_SINGLE_STEP_EN
    assign fetch_go = step;
`else
    assign fetch_go = 1'b1;
`endif

    assign state    = cur;
    assign mem_last = (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign is_reg   = (op_q == 4'b0010);
    assign is_alu   = (op_q >= 4'b0011) && (op_q <= 4'b1011);
    assign is_br    = (op_q >= 4'b1100) && (op_q <= 4'b1110);

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) cur <= S_IDLE;
        else        cur <= nxt;
    end

    // Latched instruction fields, memory wait counter and retired count.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            op_q      <= '0;
            id_q      <= 1'b0;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            case (cur)
                S_CLR: instr_cnt <= '0;
                S_FETCH: begin
                    if (fetch_go) begin
                        op_q <= opcode;
                        id_q <= identifier;
                        if (instr_cnt != {CNT_W{1'b1}})
                            instr_cnt <= instr_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: wait_cnt <= '0;
                S_MEM: if (!mem_ready) wait_cnt <= wait_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    // Next-state selection and per-state strobes.
    always_comb begin
        nxt      = cur;
        pc_clr   = 1'b0;
        pc_en    = 1'b0;
        pc_load  = 1'b0;
        ir_load  = 1'b0;
        RegWrite = 1'b0;
        AccWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        Lookup   = 1'b0;
        ImmVal   = 1'b0;
        Done     = 1'b0;
        err      = 1'b0;
        case (cur)
            S_IDLE: if (Start) nxt = S_CLR;
            S_CLR: begin
                pc_clr = 1'b1;
                nxt    = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_go) begin
                    ir_load = 1'b1;
                    nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_q == 4'b1111)      nxt = S_HALT;
                else if (op_q[3:1] == 3'b000) nxt = S_MEM;
                else                      nxt = S_EXEC;
            end
            S_EXEC: begin
                nxt = S_FETCH;
                unique case (1'b1)
                    is_reg: begin
                        RegWrite = 1'b1;
                        pc_en    = 1'b1;
                    end
                    is_alu: begin
                        AccWrite = 1'b1;
                        ImmVal   = id_q;
                        pc_en    = 1'b1;
                    end
                    is_br: begin
                        Branch  = 1'b1;
                        Lookup  = 1'b1;
                        pc_load = branch_taken;
                        pc_en   = !branch_taken;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (op_q[0]) begin
                    MemWrite = 1'b1;
                end else begin
                    MemRead = 1'b1;
                    ImmVal  = id_q;
                end
                if (mem_ready) begin
                    pc_en    = 1'b1;
                    AccWrite = !op_q[0];
                    nxt      = S_FETCH;
                end else if (mem_last) begin
                    nxt = S_ERR;
                end
            end
            S_HALT: begin
                Done = 1'b1;
                if (Start) nxt = S_CLR;
            end
            S_ERR: begin
                Done = 1'b1;
                err  = 1'b1;
                if (Start) nxt = S_CLR;
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (MEM_TIMEOUT=4).
// Strobes are compared as one packed vector per cycle.
module tb_instr_sequencer;

    localparam int CW = 16;

    localparam logic [12:0] PC_CLR = 13'h1000;
    localparam logic [12:0] PC_EN  = 13'h0800;
    localparam logic [12:0] PC_LD  = 13'h0400;
    localparam logic [12:0] IR_LD  = 13'h0200;
    localparam logic [12:0] RW     = 13'h0100;
    localparam logic [12:0] AW     = 13'h0080;
    localparam logic [12:0] MR     = 13'h0040;
    localparam logic [12:0] MW     = 13'h0020;
    localparam logic [12:0] BR     = 13'h0010;
    localparam logic [12:0] LK     = 13'h0008;
    localparam logic [12:0] IMM    = 13'h0004;
    localparam logic [12:0] DN     = 13'h0002;
    localparam logic [12:0] ER     = 13'h0001;

    logic          Clk = 1'b0;
    logic          Reset, Start, identifier, mem_ready, branch_taken;
    logic [3:0]    opcode;
    logic          pc_clr, pc_en, pc_load, ir_load;
    logic          RegWrite, AccWrite, MemRead, MemWrite;
    logic          Branch, Lookup, ImmVal, Done, err;
    logic [2:0]    state;
    logic [CW-1:0] instr_cnt;
    logic [12:0]   strobes;

    int n_cmp = 0;
    int n_bad = 0;

    instr_sequencer #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .opcode(opcode), .identifier(identifier),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_clr(pc_clr), .pc_en(pc_en), .pc_load(pc_load),
        .ir_load(ir_load), .RegWrite(RegWrite), .AccWrite(AccWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .Lookup(Lookup), .ImmVal(ImmVal), .Done(Done), .err(err),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 Clk = ~Clk;

    assign strobes = {pc_clr, pc_en, pc_load, ir_load, RegWrite,
                      AccWrite, MemRead, MemWrite, Branch, Lookup,
                      ImmVal, Done, err};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [2:0] st,
                        input logic [12:0] sb);
        chk({tag, "_st"}, 32'(state), 32'(st));
        chk({tag, "_sb"}, 32'(strobes), 32'(sb));
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    logic [3:0] prog [5];

    initial begin
        Reset = 1'b0; Start = 1'b0; opcode = 4'd0; identifier = 1'b0;
        mem_ready = 1'b0; branch_taken = 1'b0;
        prog[0] = 4'b0011; prog[1] = 4'b0010; prog[2] = 4'b1100;
        prog[3] = 4'b0001; prog[4] = 4'b1111;
        #12;
        look("rst", 3'd0, 13'h0);
        chk("rst_cnt", 32'(instr_cnt), 32'd0);
        Reset = 1'b1;
        Start = 1'b1;
        // ALU immediate instruction
        tick; look("clr", 3'd1, PC_CLR);
        Start = 1'b0; opcode = 4'b0011; identifier = 1'b1;
        tick; look("fetch1", 3'd2, IR_LD);
        chk("cnt_f1", 32'(instr_cnt), 32'd0);
        tick; look("dec1", 3'd3, 13'h0);
        chk("cnt_d1", 32'(instr_cnt), 32'd1);
        tick; look("exec_alu", 3'd4, AW | IMM | PC_EN);
        opcode = 4'b0000; identifier = 1'b0;
        // load with three MEM cycles
        tick; look("fetch2", 3'd2, IR_LD);
        tick; look("dec2", 3'd3, 13'h0);
        tick; look("mem_w1", 3'd5, MR);
        tick; look("mem_w2", 3'd5, MR);
        tick; mem_ready = 1'b1; #1;
        look("mem_rdy", 3'd5, MR | AW | PC_EN);
        tick; mem_ready = 1'b0;
        look("fetch3", 3'd2, IR_LD);
        chk("cnt_f3", 32'(instr_cnt), 32'd2);
        opcode = 4'b1101; branch_taken = 1'b1;
        // branch taken then not taken
        tick; tick; look("br_tk", 3'd4, BR | LK | PC_LD);
        branch_taken = 1'b0;
        tick; tick; tick; look("br_nt", 3'd4, BR | LK | PC_EN);
        opcode = 4'b0010;
        tick; tick; tick; look("exec_reg", 3'd4, RW | PC_EN);
        chk("cnt_reg", 32'(instr_cnt), 32'd5);
        opcode = 4'b0001;
        // store that times out
        tick; tick; tick;
        for (int i = 0; i < 4; i++) begin
            look($sformatf("mem_to%0d", i), 3'd5, MW);
            tick;
        end
        look("err", 3'd7, DN | ER);
        chk("cnt_err", 32'(instr_cnt), 32'd6);
        tick; look("err_hold", 3'd7, DN | ER);
        Start = 1'b1;
        tick; look("err_clr", 3'd1, PC_CLR);
        Start = 1'b0; mem_ready = 1'b1;
        // five-instruction program ending in halt
        tick;
        begin
            int idx = 0;
            int cyc = 0;
            while (state != 3'd6 && cyc < 60) begin
                if (state == 3'd2 && idx < 5) begin
                    opcode = prog[idx];
                    idx++;
                end
                tick;
                cyc++;
            end
        end
        look("halt", 3'd6, DN);
        chk("cnt_halt", 32'(instr_cnt), 32'd5);
        tick; look("halt_hold", 3'd6, DN);
        Start = 1'b1;
        tick; look("restart", 3'd1, PC_CLR);
        Start = 1'b0; mem_ready = 1'b0; opcode = 4'b0000; identifier = 1'b1;
        tick;
        chk("cnt_restart", 32'(instr_cnt), 32'd0);
        // asynchronous reset during MEM
        tick; tick; look("mem_imm", 3'd5, MR | IMM);
        #2 Reset = 1'b0;
        #1 look("async_rst", 3'd0, 13'h0);
        chk("async_cnt", 32'(instr_cnt), 32'd0);
        #1 Reset = 1'b1;
        Start = 1'b1; opcode = 4'b0011; identifier = 1'b0;
        tick; look("post_clr", 3'd1, PC_CLR);
        Start = 1'b0;
        tick; tick; tick; look("post_exec", 3'd4, AW | PC_EN);
        chk("post_cnt", 32'(instr_cnt), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle FSM that sequences the accumulator processor through fetch, decode, execute, memory wait and halt.
- Drives PC and IR enables, and issues the datapath strobes (RegWrite, AccWrite, MemRead, MemWrite, Branch, Lookup, ImmVal) at the correct cycle, not combinationally.
- Sits between the top level (Start/Done), the program counter, the instruction ROM/IR, and the data memory handshake.

Parameters:
- MEM_TIMEOUT, 15, max cycles spent in MEM awaiting mem_ready before error (legal 1..255).
- CNT_W, 16, width of retired-instruction counter.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin/restart program request (level, sampled in IDLE/HALT/ERR).
- opcode  in  4  instruction opcode from instruction ROM output.
- identifier  in  1  reg/imm select bit from instruction ROM output.
- mem_ready  in  1  data memory completion for current MemRead/MemWrite.
- branch_taken  in  1  branch condition from ALU/lookup path, valid in EXEC.
- pc_clr  out  1  clear PC to 0.
- pc_en  out  1  PC += 1.
- pc_load  out  1  PC <= lookup target.
- ir_load  out  1  capture instruction into IR.
- RegWrite, AccWrite, MemRead, MemWrite, Branch, Lookup, ImmVal  out  1 each  datapath strobes.
- Done  out  1  program finished (halt or error).
- err  out  1  memory timeout occurred.
- state  out  3  current FSM state encoding.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset low: async to IDLE. All outputs 0, instr_cnt=0, internal op_q/id_q/wait_cnt=0.
- Outputs are Moore-style, decoded from state plus latched op_q/id_q; never from live opcode outside FETCH.
- States (encoding): IDLE=0, CLR=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, HALT=6, ERR=7.
- IDLE: Start=1 -> CLR.
- CLR: pc_clr=1 for one cycle; instr_cnt<=0; -> FETCH.
- FETCH: ir_load=1; op_q<=opcode, id_q<=identifier at cycle end; instr_cnt+=1, saturating at all-ones; -> DECODE.
- DECODE: no strobes.
  - op_q=1111 -> HALT.
  - op_q=0000 or 0001 -> MEM with wait_cnt<=0.
  - Otherwise -> EXEC.
- EXEC: one cycle, then -> FETCH.
  - 0010: RegWrite=1, pc_en=1.
  - 0011..1011: AccWrite=1, ImmVal=id_q, pc_en=1.
  - 1100..1110: Branch=1, Lookup=1; branch_taken=1 -> pc_load=1, pc_en=0; else pc_en=1, pc_load=0.
- MEM:
  - Held strobes: MemRead=1 (op 0000, ImmVal=id_q) or MemWrite=1 (op 0001), asserted every MEM cycle.
  - mem_ready=1: pc_en=1 that cycle; AccWrite=1 same cycle for 0000; -> FETCH.
  - mem_ready=0: wait_cnt+=1.
  - wait_cnt==MEM_TIMEOUT-1 with mem_ready=0 -> ERR. Exactly MEM_TIMEOUT MEM cycles are tolerated.
- HALT: Done=1 held. Start=1 -> CLR (restart). Otherwise stay.
- ERR: Done=1, err=1 held. Start=1 -> CLR, which clears err. Otherwise stay.
- Latency: ALU/reg/branch instruction = 3 cycles; memory instruction = 2 + N cycles, N = MEM cycles (>=1).
- Start asserted while in FETCH/DECODE/EXEC/MEM is ignored.
- pc_clr, pc_en, pc_load and ir_load are mutually exclusive in every cycle.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined: adds input port step (1 bit). FSM stalls in FETCH with ir_load=0 until step=1; the step=1 cycle behaves as normal FETCH. One instruction per step pulse.
- Undefined: no step port; FETCH always completes in one cycle.

Test Plan:
- Reset, Start=1 one cycle, opcode=0011 identifier=1 -> states 1,2,3,4 on consecutive cycles; EXEC cycle has AccWrite=1, ImmVal=1, pc_en=1; instr_cnt=1.
- opcode=0000 identifier=0, mem_ready high on 3rd MEM cycle -> MemRead=1 for 3 cycles; AccWrite=1 and pc_en=1 only on 3rd; then FETCH.
- opcode=1101: branch_taken=1 -> EXEC has Branch=Lookup=pc_load=1, pc_en=0. Repeat with branch_taken=0 -> pc_en=1, pc_load=0.
- MEM_TIMEOUT=4, opcode=0001, mem_ready held 0 -> MemWrite=1 for 4 cycles, then ERR with Done=1, err=1; Start=1 -> CLR, err=0.
- Program of 5 instructions ending in 1111 -> HALT, Done=1, instr_cnt=5; Start=1 -> pc_clr=1, instr_cnt=0.
- Reset driven low mid-MEM (asynchronously, between clock edges) -> state=0 and all strobes 0 immediately; Start after release runs normally.
